// File: rtl/dbg_slave_sysclk_cmd_pkg.sv
// Shared defaults and command indices for the system-clock side of the debug slave.
// The action qualifier is the top bit of the data shift register.
package dbg_slave_pkg;

  localparam int DEF_IR_W = 2;
  localparam int DEF_SR_W = 38;

  localparam int CMD_OCIMEM    = 0;
  localparam int CMD_TRACE     = 1;
  localparam int CMD_BREAK     = 2;
  localparam int CMD_TRACECTRL = 3;

  function automatic int qual_bit(input int sr_w);
    return sr_w - 1;
  endfunction

endpackage

// File: rtl/dbg_slave_sysclk_cmd_if.sv
// Bus between the TCK-side capture logic and the system-clock command decoder.
// The slave modport is the decoder's view of the bus.
interface dbg_slave_sysclk_cmd_if
  import dbg_slave_pkg::*;
#(
  parameter int IR_W = DEF_IR_W,
  parameter int SR_W = DEF_SR_W
);
  localparam int NCMD = 2 ** IR_W;

  logic [IR_W-1:0] ir_in;
  logic [SR_W-1:0] sr;
  logic            vs_uir;
  logic            vs_udr;
  logic            cmd_ack;
  logic            overrun_clr;
  logic [SR_W-1:0] jdo;
  logic [IR_W-1:0] ir_q;
  logic [NCMD-1:0] take_action;
  logic [NCMD-1:0] take_no_action;
  logic            cmd_pending;
  logic            overrun;

  modport slave (
    input  ir_in, sr, vs_uir, vs_udr, cmd_ack, overrun_clr,
    output jdo, ir_q, take_action, take_no_action, cmd_pending, overrun
  );

  modport master (
    output ir_in, sr, vs_uir, vs_udr, cmd_ack, overrun_clr,
    input  jdo, ir_q, take_action, take_no_action, cmd_pending, overrun
  );

endinterface

// File: rtl/dbg_slave_sysclk_cmd_strobe_sync.sv
// Synchroniser for one asynchronous update strobe, followed by a registered
// rising-edge detector that only fires while the parent reports it is armed.
module dbg_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  input  logic en,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   hist_reg;
  logic                   pulse_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg  <= '0;
      hist_reg  <= 1'b0;
      pulse_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[SYNC_STAGES-2:0], strobe};
      hist_reg  <= sync_reg[SYNC_STAGES-1];
      pulse_reg <= sync_reg[SYNC_STAGES-1] & ~hist_reg & en;
    end
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/dbg_slave_sysclk_cmd.sv
// System-clock half of the debug slave: captures IR/DR on synchronised update
// strobes and issues one-cycle per-command action pulses with an ack handshake.
module dbg_slave_sysclk_cmd
  import dbg_slave_pkg::*;
#(
  parameter int                    IR_W        = DEF_IR_W,
  parameter int                    SR_W        = DEF_SR_W,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [(2**IR_W)-1:0]  CMD_EN      = '1
) (
  input  logic                    clk,
  input  logic                    reset,
  dbg_slave_sysclk_cmd_if.slave   bus
);

  localparam int NCMD  = 2 ** IR_W;
  localparam int QB    = qual_bit(SR_W);
  localparam int ARM_W = $clog2(SYNC_STAGES + 2);

  logic [ARM_W-1:0] arm_reg;
  logic             arm_ok;
  logic             uir_pulse;
  logic             udr_pulse;

  logic [SR_W-1:0]  jdo_reg, jdo_next;
  logic [IR_W-1:0]  ir_reg, ir_next;
  logic [NCMD-1:0]  act_reg, act_next;
  logic [NCMD-1:0]  nact_reg, nact_next;
  logic             pending_reg, pending_next;
  logic             overrun_reg, overrun_next;
  logic             issue;
  logic [NCMD-1:0]  sel;

  // Edges seen while the synchronisers are still settling after reset are
  // dropped, so a strobe held high across reset never fires.
  assign arm_ok = (arm_reg == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      arm_reg <= ARM_W'(SYNC_STAGES + 1);
    else if (!arm_ok)
      arm_reg <= arm_reg - ARM_W'(1);
  end

  dbg_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
    .clk    (clk),
    .reset  (reset),
    .strobe (bus.vs_uir),
    .en     (arm_ok),
    .pulse  (uir_pulse)
  );

  dbg_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
    .clk    (clk),
    .reset  (reset),
    .strobe (bus.vs_udr),
    .en     (arm_ok),
    .pulse  (udr_pulse)
  );

  // A DR update is decoded against the IR held before any same-cycle IR update.
  always_comb begin
    sel          = {{(NCMD-1){1'b0}}, 1'b1} << ir_reg;
    issue        = udr_pulse & CMD_EN[ir_reg];
    jdo_next     = udr_pulse ? bus.sr : jdo_reg;
    ir_next      = uir_pulse ? bus.ir_in : ir_reg;
    act_next     = (issue &&  bus.sr[QB]) ? sel : '0;
    nact_next    = (issue && !bus.sr[QB]) ? sel : '0;
    pending_next = issue | (pending_reg & ~bus.cmd_ack);
    overrun_next = (issue & pending_reg & ~bus.cmd_ack) |
                   (overrun_reg & ~bus.overrun_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jdo_reg     <= '0;
      ir_reg      <= '0;
      act_reg     <= '0;
      nact_reg    <= '0;
      pending_reg <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      jdo_reg     <= jdo_next;
      ir_reg      <= ir_next;
      act_reg     <= act_next;
      nact_reg    <= nact_next;
      pending_reg <= pending_next;
      overrun_reg <= overrun_next;
    end
  end

  assign bus.jdo            = jdo_reg;
  assign bus.ir_q           = ir_reg;
  assign bus.take_action    = act_reg;
  assign bus.take_no_action = nact_reg;
  assign bus.cmd_pending    = pending_reg;
  assign bus.overrun        = overrun_reg;

endmodule

// File: doc/dbg_slave_sysclk_cmd.md
Name: dbg_slave_sysclk_cmd

Overview:
Parametrised system-clock half of the debug slave. It synchronises update-IR and update-DR level strobes arriving asynchronously from the JTAG TCK domain, captures the instruction and data shift registers, and decodes them into per-instruction one-cycle take_action and take_no_action pulses. Over the fixed 2-bit/38-bit generation it adds width, depth and mask generality, a consumer ack handshake with sticky overrun detection, and post-reset pulse suppression. It sits between the virtual-JTAG TCK logic and the CPU OCI/break/trace control.

Parameters:
IR_W, 2, instruction register width; number of commands NCMD = 2**IR_W
SR_W, 38, data shift register width; bit SR_W-1 is the action qualifier
SYNC_STAGES, 2, synchroniser depth for vs_uir/vs_udr (legal 2..4)
CMD_EN, all ones (NCMD bits), per-command enable mask

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
ir_in  in  IR_W  instruction from TCK domain, stable while vs_uir is high
sr  in  SR_W  shift register from TCK domain, stable while vs_udr is high
vs_uir  in  1  async update-IR level
vs_udr  in  1  async update-DR level
cmd_ack  in  1  consumer has taken the pending command
overrun_clr  in  1  clears the sticky overrun flag
jdo  out  SR_W  captured data register
ir_q  out  IR_W  captured instruction
take_action  out  NCMD  one-hot one-cycle pulse, qualifier = 1
take_no_action  out  NCMD  one-hot one-cycle pulse, qualifier = 0
cmd_pending  out  1  a strobe has been issued and not yet acked
overrun  out  1  sticky: a new strobe arrived while pending was unacked

Behaviour:
- Reset (async, active-high): all sync flops, edge history, jdo, ir_q, both pulse vectors, cmd_pending and overrun go to 0. The arm counter loads SYNC_STAGES+1.
- Synchroniser: SYNC_STAGES flops per strobe, then a history flop. A pulse is generated when the synchronised value is 1 and the history flop is 0.
- Latency: input rise to internal pulse is SYNC_STAGES+1 clk. For udr, jdo and the output pulse register on the edge after that, so total latency is SYNC_STAGES+2.
- Arming: the arm counter decrements each cycle after reset to 0. While it is non-zero, all edge pulses are discarded. A strobe already high across reset therefore produces no output; it must fall and rise again.
- uir pulse: ir_q <= ir_in.
- udr pulse: jdo <= sr. Let k = ir_q value before any same-cycle uir update (udr belongs to the old IR).
  - If CMD_EN[k] = 1: take_action[k] <= sr[SR_W-1]; take_no_action[k] <= ~sr[SR_W-1].
  - If CMD_EN[k] = 0: only jdo updates; no pulse, no pending.
- Pulse vectors: at most one bit set in the union of both vectors. Each bit is high exactly 1 cycle and coincides with the new jdo value.
- cmd_pending: set in the cycle a pulse is issued. Cleared by cmd_ack when no pulse is issued that cycle. A pulse and cmd_ack in the same cycle leave it 1 with no overrun.
- overrun: set when a pulse is issued while cmd_pending = 1 and cmd_ack = 0. Cleared only by overrun_clr. If overrun_clr and a new overrun occur in the same cycle, set wins.
- cmd_ack while not pending is ignored.
- Back-to-back udr rises closer than SYNC_STAGES+2 clk apart are not guaranteed. Each distinct synchronised rise yields exactly one pulse; no pulse is ever duplicated.
- Reset mid-operation: an in-flight pulse is dropped, pending and overrun are cleared, and jdo returns to 0.

Decomposition:
- Package dbg_slave_pkg holds: default IR_W and SR_W, the command index constants (OCIMEM=0, TRACE=1, BREAK=2, TRACECTRL=3 for IR_W=2), and the qualifier bit position function SR_W-1.
- One sub-module, dbg_strobe_sync: SYNC_STAGES synchroniser, history flop and rising-edge output, with async active-high reset. It is instantiated twice (uir, udr). The arm counter lives in the parent.

Test Plan:
- Defaults; reset held while vs_udr=1, release, hold 10 cycles -> no pulse, jdo=0, cmd_pending=0.
- vs_uir rise with ir_in=2'd2; then vs_udr rise with sr=38'h20_0000_00AB -> after 4 clk jdo=38'h20_0000_00AB, take_action=4'b0100 for exactly 1 cycle, cmd_pending=1; cmd_ack -> cmd_pending=0.
- ir_q=1, sr[37]=0 -> take_no_action=4'b0010 for 1 cycle, take_action=0.
- Two udr commands without ack -> second pulse sets overrun=1 and it stays 1. Repeat with cmd_ack on the second pulse's cycle -> overrun=0, pending=1. overrun_clr -> overrun=0.
- CMD_EN=4'b1110, ir_q=0, udr -> jdo updates, no pulse, pending stays 0.
- IR_W=3, SR_W=44, SYNC_STAGES=3: ir=3'd5, udr -> take_action=8'b0010_0000 after 5 clk; reset asserted mid-sync -> no pulse after release.
